demux_dispatch_ctrl: RTL and testbench
======================================

Name: demux_dispatch_ctrl

Overview:
- Sequencing controller for the 1-to-4 demux datapath: holds one input word and drives exactly one of four output channels with valid/ready handshakes.
- Channel comes from the word's select field (ADDR mode) or a round-robin pointer (RR mode).
- A hold timeout drops words addressed to a stalled channel.
- Sits between a single producer and four consumer lanes.

Parameters:
- DW, 8, data word width.
- TIMEOUT, 16, max stall cycles in HOLD before drop; 0 disables the drop.
- CW, 5, width of the stall counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk.
- mode  input  1  0 = ADDR (use in_sel), 1 = RR (ignore in_sel).
- in_valid  input  1  producer word valid.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  DW  producer word.
- in_sel  input  2  destination channel, ADDR mode only.
- out_valid  output  4  one-hot channel valid.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  DW  shared data to all channels.
- drop  output  1  one-cycle pulse when a word is discarded by timeout.
- busy  output  1  buffer occupied (state HOLD).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, buf cleared, out_valid=0, out_data=0, drop=0, busy=0, rr_ptr=0, stall_cnt=0.
  - Reset mid-HOLD discards the held word without a drop pulse.
- States: IDLE (buffer empty), HOLD (buffer full).
- in_ready:
  - 1 in IDLE.
  - In HOLD, in_ready = out_ready[buf_sel]; delivery and refill can occur in the same cycle.
  - Forced 0 in the cycle a drop fires.
- Accept (in_valid & in_ready):
  - buf_data<=in_data.
  - buf_sel<=in_sel (ADDR) or rr_ptr (RR).
  - In RR, rr_ptr<=rr_ptr+1, mod 4 wrap 3->0.
  - state<=HOLD, stall_cnt<=0.
- Latency: word appears on out_data/out_valid the cycle after acceptance. No combinational in->out path.
- HOLD outputs:
  - out_valid = one-hot(buf_sel), out_data = buf_data, busy=1.
  - Outside HOLD: out_valid=0, out_data=0.
- Delivery (HOLD & out_ready[buf_sel]):
  - With a simultaneous accept: stay in HOLD with the new word.
  - Otherwise: go to IDLE.
  - out_ready of non-selected channels is ignored.
- Stall:
  - In HOLD with out_ready[buf_sel]=0, stall_cnt increments.
  - If TIMEOUT>0 and stall_cnt==TIMEOUT-1 while still stalled:
    - next cycle: state=IDLE, drop=1 for one cycle, buffer cleared.
  - A drop does not rewind rr_ptr.
- Timing limits: a word is presented for at most TIMEOUT cycles. With TIMEOUT=0 it is held indefinitely.
- Mode change: takes effect at the next accept. The held word keeps its latched buf_sel.
- in_sel, in_data and mode are don't-care when in_valid=0.

Optional Feature:
- Macro: DEMUX_DISPATCH_STATS_EN.
- When defined, adds:
  - output ch_count, 4x16 bits, packed {ch3,ch2,ch1,ch0}: per-channel delivered-word counters that saturate at 0xFFFF.
  - output drop_count, 16 bits: saturating drop counter.
  - All counters clear on reset.
- When undefined: these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4.
  - Typedef ch_sel_t (2-bit).
  - State enum {IDLE, HOLD}.
  - Mode constants MODE_ADDR=0, MODE_RR=1.
  - Function onehot4(ch_sel_t) returning 4-bit.
- One natural sub-module: demux_rr_ptr, holding the 2-bit wrap-around pointer with advance enable and synchronous reset.
- The FSM, buffer and stall counter stay in the top module.

Test Plan:
- ADDR basic: mode=0, in_sel=2, in_data=0xA5, out_ready=4'b0100.
  - Cycle+1: out_valid=4'b0100, out_data=0xA5.
  - Cycle+2: busy=0, out_valid=0.
- RR rotation: mode=1, out_ready=4'hF, six back-to-back words 0x10..0x15.
  - out_valid sequence 0001,0010,0100,1000,0001,0010, one word per cycle, in_ready held 1.
- Backpressure: ADDR, in_sel=1, out_ready=0 for 5 cycles, then 4'b0010.
  - in_ready=0 and out_valid=4'b0010 stable throughout; delivered on the cycle ready rises.
  - A second word waiting on in_valid is accepted in that same cycle.
- Timeout: TIMEOUT=4, in_sel=3, out_ready=0.
  - out_valid=4'b1000 for exactly 4 cycles, then drop=1 for one cycle, state IDLE, in_ready=1.
  - With stats enabled: drop_count=1.
- Reset mid-operation: held word on ch0 and rr_ptr=2, assert rst_n=0 for one edge.
  - Next cycle: out_valid=0, out_data=0, busy=0, drop=0.
  - The next RR word goes to ch0.
- TIMEOUT=0: out_ready=0 for 100 cycles.
  - Never drops; word delivered when out_ready[sel] rises.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-4 demux dispatch controller.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  function automatic logic [3:0] onehot4(ch_sel_t sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Two-bit round-robin channel pointer; wraps 3 -> 0 on each advance.
module demux_rr_ptr
  import demux_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    adv,
  output ch_sel_t ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr + 2'd1;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-word buffered 1-to-4 dispatch controller with stall timeout.
// Optional per-channel statistics counters under DEMUX_DISPATCH_STATS_EN.
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  ch_sel_t       in_sel,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic          drop,
  output logic          busy
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  output logic [63:0]   ch_count,
  output logic [15:0]   drop_count
`endif
);

  state_e        state;
  logic [DW-1:0] buf_data;
  ch_sel_t       buf_sel;
  logic [CW-1:0] stall_cnt;
  ch_sel_t       rr_ptr;

  logic    hold;
  logic    sel_ready;
  logic    accept;
  logic    deliver;
  logic    timeout_hit;
  ch_sel_t next_sel;

  always_comb begin
    hold        = (state == HOLD);
    sel_ready   = out_ready[buf_sel];
    // drop is only ever high in IDLE, so this also blocks refill in the drop cycle
    in_ready    = hold ? sel_ready : ~drop;
    accept      = in_valid & in_ready;
    deliver     = hold & sel_ready;
    timeout_hit = (TIMEOUT != 0) && hold && !sel_ready &&
                  (stall_cnt == CW'(TIMEOUT - 1));
    next_sel    = (mode == MODE_RR) ? rr_ptr : in_sel;
  end

  demux_rr_ptr u_rr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (accept && (mode == MODE_RR)),
    .ptr   (rr_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      buf_data  <= '0;
      buf_sel   <= '0;
      stall_cnt <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (accept) begin
        state     <= HOLD;
        buf_data  <= in_data;
        buf_sel   <= next_sel;
        stall_cnt <= '0;
      end else if (deliver || timeout_hit) begin
        state     <= IDLE;
        buf_data  <= '0;
        buf_sel   <= '0;
        stall_cnt <= '0;
        drop      <= timeout_hit;
      end else if (hold) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = hold ? onehot4(buf_sel) : 4'b0000;
    out_data  = hold ? buf_data : '0;
    busy      = hold;
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [15:0] ch_cnt [NUM_CH];
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (deliver && (buf_sel == ch_sel_t'(i)) && (ch_cnt[i] != 16'hFFFF)) begin
          ch_cnt[i] <= ch_cnt[i] + 16'd1;
        end
      end
      if (timeout_hit && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign ch_count   = {ch_cnt[3], ch_cnt[2], ch_cnt[1], ch_cnt[0]};
  assign drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: vector table plus hand sequences, scoreboard on deliveries.
module tb_demux_dispatch_ctrl;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic [7:0] in_data;
  ch_sel_t    in_sel;
  logic [3:0] out_ready;

  logic       ir_m, drop_m, busy_m, ir_t4, drop_t4, busy_t4, ir_t0, drop_t0, busy_t0;
  logic [3:0] ov_m, ov_t4, ov_t0;
  logic [7:0] od_m, od_t4, od_t0;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic [63:0] cc_m, cc_t4, cc_t0;
  logic [15:0] dc_m, dc_t4, dc_t0;
`endif

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DW(8), .TIMEOUT(16), .CW(5)) u_main (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir_m),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov_m), .out_ready(out_ready),
    .out_data(od_m), .drop(drop_m), .busy(busy_m)
`ifdef DEMUX_DISPATCH_STATS_EN
    , .ch_count(cc_m), .drop_count(dc_m)
`endif
  );

  demux_dispatch_ctrl #(.DW(8), .TIMEOUT(4), .CW(3)) u_t4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir_t4),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov_t4), .out_ready(out_ready),
    .out_data(od_t4), .drop(drop_t4), .busy(busy_t4)
`ifdef DEMUX_DISPATCH_STATS_EN
    , .ch_count(cc_t4), .drop_count(dc_t4)
`endif
  );

  demux_dispatch_ctrl #(.DW(8), .TIMEOUT(0), .CW(5)) u_t0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir_t0),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov_t0), .out_ready(out_ready),
    .out_data(od_t0), .drop(drop_t0), .busy(busy_t0)
`ifdef DEMUX_DISPATCH_STATS_EN
    , .ch_count(cc_t0), .drop_count(dc_t0)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic       vld;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ordy;
    logic [3:0] e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    logic       e_busy;
  } vec_t;

  typedef struct {
    logic [3:0] ov;
    logic [7:0] d;
  } exp_t;

  vec_t       vecs[11];
  exp_t       sb_q[$];
  bit         sb_en = 1'b0;
  logic [1:0] m_rr;

  // Scoreboard: every delivery on u_main must match the oldest expected word
  always @(negedge clk) begin
    if (sb_en && rst_n && ((ov_m & out_ready) != 4'b0000)) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow at %0t: got delivery ov=0x%0h, expected none", $time, ov_m);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_channel", ov_m, e.ov);
        chk("sb_data", od_m, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    mode      = MODE_ADDR;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    m_rr = 2'd0;
  endtask

  task automatic drive(input logic md, input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r);
    mode = md; in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    exp_t e;
    //         mode vld sel data  ordy     e_ov     e_od  ir busy
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0100, 4'b0000, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 4'b0100, 8'hA5, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 4'b0000, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'd3, 8'h10, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd3, 8'h11, 4'b1111, 4'b0001, 8'h10, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 8'h12, 4'b1111, 4'b0010, 8'h11, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 8'h13, 4'b1111, 4'b0100, 8'h12, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 8'h14, 4'b1111, 4'b1000, 8'h13, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 2'd3, 8'h15, 4'b1111, 4'b0001, 8'h14, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 4'b0010, 8'h15, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 4'b0000; mode = 1'b0;
    in_sel = 2'd0; in_data = 8'h00;
    step();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", ov_m, 4'b0000);
    chk("rst_out_data", od_m, 8'h00);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_drop", drop_m, 1'b0);
    chk("rst_in_ready", ir_m, 1'b1);
    chk("rst_t4_busy", busy_t4, 1'b0);
    chk("rst_t0_busy", busy_t0, 1'b0);
    step();

    // ADDR basic followed by RR rotation
    sb_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].mode, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), ov_m, vecs[i].e_ov);
      chk($sformatf("vec%0d_out_data", i), od_m, vecs[i].e_od);
      chk($sformatf("vec%0d_in_ready", i), ir_m, vecs[i].e_ir);
      chk($sformatf("vec%0d_busy", i), busy_m, vecs[i].e_busy);
      if (vecs[i].vld && vecs[i].e_ir) begin
        e.ov = onehot4(vecs[i].mode ? m_rr : vecs[i].sel);
        e.d  = vecs[i].data;
        sb_q.push_back(e);
        if (vecs[i].mode) m_rr = m_rr + 2'd1;
      end
      step();
    end
`ifdef DEMUX_DISPATCH_STATS_EN
    chk("stats_ch_count", cc_m, 64'h0001_0002_0002_0002);
`endif

    // Backpressure: ch1 stalls 5 cycles, second word accepted on delivery
    do_reset();
    drive(MODE_ADDR, 1'b1, 2'd1, 8'hC3, 4'b0000);
    @(negedge clk);
    chk("bp_first_in_ready", ir_m, 1'b1);
    e.ov = 4'b0010; e.d = 8'hC3; sb_q.push_back(e);
    step();
    drive(MODE_ADDR, 1'b1, 2'd2, 8'h3C, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_in_ready", k), ir_m, 1'b0);
      chk($sformatf("bp_stall%0d_out_valid", k), ov_m, 4'b0010);
      chk($sformatf("bp_stall%0d_out_data", k), od_m, 8'hC3);
      step();
    end
    out_ready = 4'b0010;
    @(negedge clk);
    chk("bp_release_in_ready", ir_m, 1'b1);
    chk("bp_release_out_valid", ov_m, 4'b0010);
    e.ov = 4'b0100; e.d = 8'h3C; sb_q.push_back(e);
    step();
    drive(MODE_ADDR, 1'b0, 2'd0, 8'h00, 4'b0100);
    @(negedge clk);
    chk("bp_second_out_valid", ov_m, 4'b0100);
    chk("bp_second_out_data", od_m, 8'h3C);
    step();
    @(negedge clk);
    chk("bp_idle_busy", busy_m, 1'b0);
    chk("bp_sb_empty", sb_q.size(), 0);
    step();

    // Timeout on the TIMEOUT=4 instance
    sb_en = 1'b0;
    do_reset();
    drive(MODE_ADDR, 1'b1, 2'd3, 8'h77, 4'b0000);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("to_hold%0d_out_valid", k), ov_t4, 4'b1000);
      chk($sformatf("to_hold%0d_drop", k), drop_t4, 1'b0);
      step();
    end
    @(negedge clk);
    chk("to_drop_pulse", drop_t4, 1'b1);
    chk("to_drop_out_valid", ov_t4, 4'b0000);
    chk("to_drop_busy", busy_t4, 1'b0);
    chk("to_drop_in_ready", ir_t4, 1'b0);
`ifdef DEMUX_DISPATCH_STATS_EN
    chk("to_drop_count", dc_t4, 16'd1);
`endif
    step();
    @(negedge clk);
    chk("to_after_drop", drop_t4, 1'b0);
    chk("to_after_in_ready", ir_t4, 1'b1);
    step();

    // Reset mid-HOLD with rr_ptr=2
    sb_en = 1'b1;
    do_reset();
    drive(MODE_RR, 1'b1, 2'd3, 8'h21, 4'b1111);
    e.ov = 4'b0001; e.d = 8'h21; sb_q.push_back(e);
    step();
    drive(MODE_RR, 1'b1, 2'd3, 8'h22, 4'b1111);
    e.ov = 4'b0010; e.d = 8'h22; sb_q.push_back(e);
    step();
    drive(MODE_ADDR, 1'b1, 2'd0, 8'hEE, 4'b1111);
    step();
    drive(MODE_ADDR, 1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("mr_held_out_valid", ov_m, 4'b0001);
    chk("mr_held_out_data", od_m, 8'hEE);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    drive(MODE_RR, 1'b1, 2'd2, 8'h99, 4'b1111);
    @(negedge clk);
    chk("mr_out_valid", ov_m, 4'b0000);
    chk("mr_out_data", od_m, 8'h00);
    chk("mr_busy", busy_m, 1'b0);
    chk("mr_drop", drop_m, 1'b0);
    e.ov = 4'b0001; e.d = 8'h99; sb_q.push_back(e);
    step();
    drive(MODE_RR, 1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);
    chk("mr_rr_restart", ov_m, 4'b0001);
    step();
    @(negedge clk);
    chk("mr_sb_empty", sb_q.size(), 0);
    step();

    // TIMEOUT=0 instance holds indefinitely; non-selected readies ignored
    sb_en = 1'b0;
    do_reset();
    drive(MODE_ADDR, 1'b1, 2'd1, 8'h5A, 4'b0000);
    step();
    drive(MODE_ADDR, 1'b0, 2'd0, 8'h00, 4'b1101);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ov_t0 !== 4'b0010 || od_t0 !== 8'h5A || drop_t0 !== 1'b0 || ir_t0 !== 1'b0) bad++;
      step();
    end
    chk("t0_stall_bad_cycles", bad, 0);
    out_ready = 4'b0010;
    @(negedge clk);
    chk("t0_release_out_valid", ov_t0, 4'b0010);
    chk("t0_release_out_data", od_t0, 8'h5A);
    chk("t0_release_in_ready", ir_t0, 1'b1);
    step();
    @(negedge clk);
    chk("t0_idle_busy", busy_t0, 1'b0);
    chk("t0_idle_out_valid", ov_t0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
